// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit scheduler: defaults, frame length and sequencer states.
package i2s_pkg;

  localparam int unsigned WORD_SIZE_DEFAULT = 24;
  localparam logic [15:0] UNDERRUN_MAX      = 16'hFFFF;

  localparam logic [0:0] StPrime = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  // One load period followed by the left and right data words.
  function automatic int unsigned frame_bclks(input int unsigned word_size);
    return 2 * word_size + 1;
  endfunction

endpackage

// File: rtl/i2s_tx_scheduler_if.sv
// Valid/ready sample-pair stream from the synth core into the transmit scheduler.
interface i2s_tx_scheduler_if #(
  parameter int unsigned WORD_SIZE = 24
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_left;
  logic [WORD_SIZE-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO of stereo sample pairs; head entry is always visible on pop_data.
module sample_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nReset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [LvlW-1:0]  lvl_q, lvl_d;
  logic             do_push, do_pop;

  assign do_push = push && (lvl_q != LvlW'(DEPTH));
  assign do_pop  = pop && (lvl_q != '0);

  always_comb begin
    lvl_d = lvl_q;
    if (do_push && !do_pop) begin
      lvl_d = lvl_q + LvlW'(1);
    end else if (do_pop && !do_push) begin
      lvl_d = lvl_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (do_pop)  rd_q <= rd_q + PtrW'(1);
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_q];
  assign level    = lvl_q;

endmodule

// File: rtl/i2s_tx_scheduler.sv
// I2S frame scheduler: divides clk into bclk, buffers sample pairs and presents one held
// left/right pair per frame, with priming, mute and underrun accounting.
module i2s_tx_scheduler
  import i2s_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = WORD_SIZE_DEFAULT,
  parameter int unsigned BCLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FRAME_BCLKS = frame_bclks(WORD_SIZE)
) (
  input  logic                          clk,
  input  logic                          nReset,
  i2s_tx_scheduler_if.slave             up,
  input  logic                          mute,
  input  logic                          clear_underrun,
  output logic                          bclk,
  output logic [WORD_SIZE-1:0]          left_data,
  output logic [WORD_SIZE-1:0]          right_data,
  output logic                          frame_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_count
);

  localparam int unsigned DivW = $clog2(BCLK_DIV);
  localparam int unsigned FrmW = $clog2(FRAME_BCLKS);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic [DivW-1:0]        div_q, div_d;
  logic [FrmW-1:0]        bcnt_q, bcnt_d;
  logic                   bclk_q;
  logic [0:0]             state_q, state_d;
  logic [WORD_SIZE-1:0]   left_q, left_d, right_q, right_d;
  logic [15:0]            urun_q, urun_d;
  logic [2*WORD_SIZE-1:0] head;
  logic                   boundary, in_ready, push, pop, go_run, underrun;

  assign boundary = (div_q == '0) && (bcnt_q == '0);
  // Gated by nReset so neither strobe is seen while the block is held in reset.
  assign frame_start = boundary && nReset;
  assign in_ready    = nReset && (fifo_level < LvlW'(FIFO_DEPTH));
  assign up.in_ready = in_ready;
  assign push        = up.in_valid && in_ready;

  // The boundary that leaves PRIME already behaves as a RUN boundary.
  assign go_run   = boundary && ((state_q == StRun) || (fifo_level >= LvlW'(FIFO_DEPTH / 2)));
  assign pop      = go_run && (fifo_level != '0);
  assign underrun = go_run && (fifo_level == '0);

  always_comb begin
    div_d   = (div_q == DivW'(BCLK_DIV - 1)) ? '0 : div_q + DivW'(1);
    bcnt_d  = bcnt_q;
    if (div_q == DivW'(BCLK_DIV - 1)) begin
      bcnt_d = (bcnt_q == FrmW'(FRAME_BCLKS - 1)) ? '0 : bcnt_q + FrmW'(1);
    end

    state_d = go_run ? StRun : state_q;

    left_d  = left_q;
    right_d = right_q;
    if (boundary) begin
      left_d  = '0;
      right_d = '0;
      if (pop && !mute) begin
        left_d  = head[2*WORD_SIZE-1:WORD_SIZE];
        right_d = head[WORD_SIZE-1:0];
      end
    end

    urun_d = urun_q;
    if (clear_underrun) begin
      urun_d = '0;
    end else if (underrun && (urun_q != UNDERRUN_MAX)) begin
      urun_d = urun_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      div_q   <= '0;
      bcnt_q  <= '0;
      bclk_q  <= 1'b0;
      state_q <= StPrime;
      left_q  <= '0;
      right_q <= '0;
      urun_q  <= '0;
    end else begin
      div_q   <= div_d;
      bcnt_q  <= bcnt_d;
      bclk_q  <= (div_q < DivW'(BCLK_DIV / 2));
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      urun_q  <= urun_d;
    end
  end

  sample_fifo #(
    .WIDTH (2 * WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nReset    (nReset),
    .push      (push),
    .push_data ({up.in_left, up.in_right}),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level)
  );

  assign bclk           = bclk_q;
  assign left_data      = left_q;
  assign right_data     = right_q;
  assign underrun_count = urun_q;

endmodule
